// File: rtl/cpu_pkg.sv
// Shared constants and selector enum for the 16-bit CPU front end.
// The return-address stack in fetch_unit is enabled with FETCH_STACK_EN.
package cpu_pkg;

  localparam int WIDTH  = 16;
  localparam int NWORDS = 1024;
  localparam int AW     = $clog2(NWORDS);

  localparam logic [AW-1:0] RESET_PC = '0;

  typedef enum logic [2:0] {
    SEL_INC,
    SEL_BRANCH,
    SEL_JUMP,
    SEL_CALL,
    SEL_RET
  } next_pc_sel_t;

endpackage

// File: rtl/fetch_stack.sv
// Return-address LIFO for fetch_unit; a push while full drops the oldest entry.
// Only instantiated when FETCH_STACK_EN is defined.
module fetch_stack
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int DW    = AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] top,
  output logic          empty,
  output logic          full
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] count;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign top_idx = IW'(count - CW'(1));
  assign wr_idx  = IW'(count);
  // Popping an empty stack yields 0 so a bad return lands at address 0.
  assign top     = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      if (full) begin
        for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i+1];
        mem[DEPTH-1] <= din;
      end else begin
        mem[wr_idx] <= din;
        count       <= count + CW'(1);
      end
    end else if (pop && !empty) begin
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, instruction register and redirect handling.
// Define FETCH_STACK_EN to enable call/return through the hardware stack.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             jump,
  input  logic             branch,
  input  logic             call,
  input  logic             ret,
  input  logic [AW-1:0]    jump_addr,
  input  logic [AW-1:0]    branch_off,
  input  logic [WIDTH-1:0] instr_in,
  output logic [AW-1:0]    pc_addr,
  output logic [WIDTH-1:0] ir,
  output logic [AW-1:0]    ir_pc,
  output logic             ir_valid,
  output logic             stack_err
);

  logic [AW-1:0] pc;
  logic [AW-1:0] target;
  logic [AW-1:0] ret_addr;
  logic          ret_en;
  next_pc_sel_t  sel;

`ifdef FETCH_STACK_EN
  logic [AW-1:0] stack_top;
  logic          stack_empty;
  logic          stack_full;
  logic          push;
  logic          pop;
  logic          err;

  assign ret_en   = ret;
  assign ret_addr = stack_top;
  assign push     = !stall && (sel == SEL_CALL);
  assign pop      = !stall && (sel == SEL_RET);

  fetch_stack #(
    .DEPTH (DEPTH),
    .DW    (AW)
  ) u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (ir_pc + AW'(1)),
    .top   (stack_top),
    .empty (stack_empty),
    .full  (stack_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if ((push && stack_full) || (pop && stack_empty)) begin
      err <= 1'b1;
    end
  end

  assign stack_err = err;
`else
  logic unused_ret;

  assign unused_ret = ret;
  assign ret_en     = 1'b0;
  assign ret_addr   = '0;
  assign stack_err  = 1'b0;
`endif

  // Redirects only count when they come from a valid decoded instruction.
  always_comb begin
    sel = SEL_INC;
    if (ir_valid) begin
      if (ret_en)      sel = SEL_RET;
      else if (call)   sel = SEL_CALL;
      else if (jump)   sel = SEL_JUMP;
      else if (branch) sel = SEL_BRANCH;
    end
  end

  always_comb begin
    target = pc + AW'(1);
    case (sel)
      SEL_BRANCH: target = ir_pc + branch_off;
      SEL_JUMP:   target = jump_addr;
      SEL_CALL:   target = jump_addr;
      SEL_RET:    target = ret_addr;
      default:    target = pc + AW'(1);
    endcase
  end

  // On a redirect the word fetched from the old pc is captured but flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc       <= RESET_PC;
      ir       <= '0;
      ir_pc    <= '0;
      ir_valid <= 1'b0;
    end else if (!stall) begin
      pc       <= target;
      ir       <= instr_in;
      ir_pc    <= pc;
      ir_valid <= (sel == SEL_INC);
    end
  end

  assign pc_addr = pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit against a queue-based reference model.
// Follows FETCH_STACK_EN so the model matches whichever build is compiled.
module tb_fetch_unit;

  localparam int AW     = 10;
  localparam int WIDTH  = 16;
  localparam int NWORDS = 1024;
  localparam int DEPTH  = 4;
`ifdef FETCH_STACK_EN
  localparam bit STACK_EN = 1'b1;
`else
  localparam bit STACK_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             stall = 1'b0;
  logic             jump = 1'b0;
  logic             branch = 1'b0;
  logic             call = 1'b0;
  logic             ret = 1'b0;
  logic [AW-1:0]    jump_addr = '0;
  logic [AW-1:0]    branch_off = '0;
  logic [WIDTH-1:0] instr_in;
  logic [AW-1:0]    pc_addr;
  logic [WIDTH-1:0] ir;
  logic [AW-1:0]    ir_pc;
  logic             ir_valid;
  logic             stack_err;

  logic [WIDTH-1:0] prog [NWORDS];

  int checks = 0;
  int failures = 0;

  int m_pc;
  int m_ir;
  int m_ir_pc;
  bit m_valid;
  bit m_err;
  int m_stack [$];

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .jump       (jump),
    .branch     (branch),
    .call       (call),
    .ret        (ret),
    .jump_addr  (jump_addr),
    .branch_off (branch_off),
    .instr_in   (instr_in),
    .pc_addr    (pc_addr),
    .ir         (ir),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .stack_err  (stack_err)
  );

  always #5 clk = ~clk;

  assign instr_in = prog[pc_addr];

  task automatic check_one(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput();
    check_one("pc_addr", 32'(pc_addr), 32'(m_pc));
    check_one("ir", 32'(ir), 32'(m_ir));
    check_one("ir_pc", 32'(ir_pc), 32'(m_ir_pc));
    check_one("ir_valid", 32'(ir_valid), 32'(m_valid));
    check_one("stack_err", 32'(stack_err), 32'(m_err));
  endtask

  task automatic model_reset();
    m_pc = 0;
    m_ir = 0;
    m_ir_pc = 0;
    m_valid = 1'b0;
    m_err = 1'b0;
    m_stack.delete();
  endtask

  // One clock of the fetch stage described by its architectural rules.
  task automatic model_step();
    bit redirect;
    int tgt;
    if (stall) return;
    redirect = 1'b0;
    tgt = 0;
    if (m_valid) begin
      if (ret && STACK_EN) begin
        redirect = 1'b1;
        if (m_stack.size() == 0) begin
          tgt = 0;
          m_err = 1'b1;
        end else begin
          tgt = m_stack.pop_back();
        end
      end else if (call) begin
        redirect = 1'b1;
        tgt = int'(jump_addr);
        if (STACK_EN) begin
          if (m_stack.size() == DEPTH) begin
            void'(m_stack.pop_front());
            m_err = 1'b1;
          end
          m_stack.push_back((m_ir_pc + 1) % NWORDS);
        end
      end else if (jump) begin
        redirect = 1'b1;
        tgt = int'(jump_addr);
      end else if (branch) begin
        redirect = 1'b1;
        tgt = (m_ir_pc + int'(branch_off)) % NWORDS;
      end
    end
    m_ir = int'(prog[m_pc]);
    m_ir_pc = m_pc;
    m_valid = !redirect;
    m_pc = redirect ? tgt : (m_pc + 1) % NWORDS;
  endtask

  task automatic applyStimulus(input bit s, input bit j, input bit b, input bit c, input bit r,
                               input int ja, input int bo);
    stall = s;
    jump = j;
    branch = b;
    call = c;
    ret = r;
    jump_addr = AW'(ja);
    branch_off = AW'(bo);
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset lands mid-cycle; outputs must clear without waiting for an edge.
  task automatic mid_reset();
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput();
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) prog[i] = WIDTH'($urandom);

    #2;
    reset = 1'b0;
    #1;
    model_reset();
    checkOutput();
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] sequential fetch after reset");
    for (int i = 0; i < 5; i++) step();

    $display("[TB] wrap at top of memory");
    applyStimulus(0, 1, 0, 0, 0, 1023, 0);
    step();
    idle();
    step();
    check_one("wrap_pc", 32'(pc_addr), 32'd0);
    check_one("wrap_ir_pc", 32'(ir_pc), 32'd1023);

    $display("[TB] backward branch");
    applyStimulus(0, 1, 0, 0, 0, 20, 0);
    step();
    idle();
    step();
    applyStimulus(0, 0, 1, 0, 0, 0, 'h3FC);
    step();
    check_one("branch_pc", 32'(pc_addr), 32'd16);
    idle();
    step();
    check_one("branch_ir_pc", 32'(ir_pc), 32'd16);

    $display("[TB] call and return");
    applyStimulus(0, 1, 0, 0, 0, 100, 0);
    step();
    idle();
    step();
    applyStimulus(0, 0, 0, 1, 0, 300, 0);
    step();
    check_one("call_pc", 32'(pc_addr), 32'd300);
    idle();
    step();
    applyStimulus(0, 0, 0, 0, 1, 0, 0);
    step();
    idle();
    step();

    $display("[TB] nested calls beyond stack depth");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 1, 0, 200 + i * 37, 0);
      step();
      idle();
      step();
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 0, 0, 1, 0, 0);
      step();
      idle();
      step();
    end

    $display("[TB] stall holds the stage");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 0, 0, 0, 777, 0);
      step();
    end
    idle();
    step();
    step();

    $display("[TB] ret outranks jump");
    applyStimulus(0, 0, 0, 1, 0, 640, 0);
    step();
    idle();
    step();
    applyStimulus(0, 1, 0, 0, 1, 500, 0);
    step();
    idle();
    step();

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 7) == 0, int'($urandom_range(0, NWORDS - 1)),
                    int'($urandom_range(0, NWORDS - 1)));
      step();
      if (i == 200) begin
        idle();
        mid_reset();
      end
    end

    $display("[TB] asynchronous reset mid-run");
    idle();
    step();
    mid_reset();
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
